// File: rtl/jtframe_sdram_pkg.sv
// ============================================================================
// Module      : jtframe_sdram_pkg
// Description : Shared sizes and FSM encodings for the SDRAM read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jtframe_sdram_pkg;

    localparam int SLOT_COUNT = 2;
    localparam int ADDR_W     = 22;
    localparam int TAG_W      = 21;
    localparam int DATA_W     = 32;
    localparam int BANK_W     = 2;
    localparam int ST_W       = 2;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_WAIT_ACK  = 2'd1;
    localparam state_t ST_WAIT_DATA = 2'd2;

    // A tag names a 32-bit word pair; the SDRAM is addressed at its even word
    function automatic logic [ADDR_W-1:0] pair_addr(input logic [TAG_W-1:0] tag);
        return {tag, 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtframe_sdram_slot.sv
// ============================================================================
// Module      : jtframe_sdram_slot
// Description : One-entry read cache for a game slot, with hit/pending logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtframe_sdram_slot
    import jtframe_sdram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_downloading,
    input  logic              i_cs,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_in_flight,
    input  logic              i_fill,
    input  logic [TAG_W-1:0]  i_fill_tag,
    input  logic [DATA_W-1:0] i_fill_data,
    output logic              o_pending,
    output logic              o_ok,
    output logic [DATA_W-1:0] o_dout
);

    logic              r_valid;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_data;
    logic              r_ok;
    logic              w_hit;

    assign w_hit     = i_cs && r_valid && (r_tag == i_tag);
    // The owner of the outstanding read must not re-request its own miss
    assign o_pending = i_cs && !w_hit && !i_in_flight;
    assign o_ok      = r_ok;
    assign o_dout    = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
            r_ok    <= 1'b0;
        end else begin
            r_ok <= w_hit && !i_downloading;
            if (i_downloading) begin
                r_valid <= 1'b0;
            end else if (i_fill) begin
                r_valid <= 1'b1;
                r_tag   <= i_fill_tag;
                r_data  <= i_fill_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/jtframe_sdram_arb2.sv
// ============================================================================
// Module      : jtframe_sdram_arb2
// Description : Two-slot cached SDRAM read arbiter with round-robin grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtframe_sdram_arb2
    import jtframe_sdram_pkg::*;
#(
    parameter logic [BANK_W-1:0] SLOT0_BANK = 2'd0,
    parameter logic [BANK_W-1:0] SLOT1_BANK = 2'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              downloading,
    input  logic              slot0_cs,
    input  logic [ADDR_W-1:0] slot0_addr,
    output logic              slot0_ok,
    output logic [DATA_W-1:0] slot0_dout,
    input  logic              slot1_cs,
    input  logic [ADDR_W-1:0] slot1_addr,
    output logic              slot1_ok,
    output logic [DATA_W-1:0] slot1_dout,
    output logic              read_req,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BANK_W-1:0] sdram_bank,
    output logic              sdram_rnw,
    output logic              refresh_en,
    input  logic              sdram_ack,
    input  logic              data_rdy,
    input  logic [DATA_W-1:0] data_read
);

    state_t              r_state, w_state_nxt;
    logic                r_owner, w_owner_nxt;
    logic                r_last, w_last_nxt;
    logic                r_read_req, w_read_req_nxt;
    logic                r_refresh_en;
    logic [ADDR_W-1:0]   r_sdram_addr, w_sdram_addr_nxt;
    logic [BANK_W-1:0]   r_sdram_bank, w_sdram_bank_nxt;
    logic [TAG_W-1:0]    r_tag, w_tag_nxt;
    logic                w_grant;

    logic [SLOT_COUNT-1:0] w_cs, w_pending, w_in_flight, w_fill, w_ok;
    logic [TAG_W-1:0]      w_slot_tag [SLOT_COUNT];
    logic [DATA_W-1:0]     w_dout     [SLOT_COUNT];
    logic                  w_unused_lsb;

    assign w_cs          = {slot1_cs, slot0_cs};
    assign w_slot_tag[0] = slot0_addr[ADDR_W-1:1];
    assign w_slot_tag[1] = slot1_addr[ADDR_W-1:1];
    assign w_unused_lsb  = slot0_addr[0] ^ slot1_addr[0];

    generate
        for (genvar i = 0; i < SLOT_COUNT; i++) begin : g_slot
            assign w_in_flight[i] = (r_state != ST_IDLE) && (r_owner == 1'(i));

            jtframe_sdram_slot u_slot (
                .clk           (clk),
                .rst           (rst),
                .i_downloading (downloading),
                .i_cs          (w_cs[i]),
                .i_tag         (w_slot_tag[i]),
                .i_in_flight   (w_in_flight[i]),
                .i_fill        (w_fill[i]),
                .i_fill_tag    (r_tag),
                .i_fill_data   (data_read),
                .o_pending     (w_pending[i]),
                .o_ok          (w_ok[i]),
                .o_dout        (w_dout[i])
            );
        end
    endgenerate

    assign slot0_ok   = w_ok[0];
    assign slot1_ok   = w_ok[1];
    assign slot0_dout = w_dout[0];
    assign slot1_dout = w_dout[1];
    assign read_req   = r_read_req;
    assign sdram_addr = r_sdram_addr;
    assign sdram_bank = r_sdram_bank;
    assign sdram_rnw  = 1'b1;
    assign refresh_en = r_refresh_en;

    // The priority pointer only moves when both slots contend
    assign w_grant = (w_pending[0] && w_pending[1]) ? ~r_last : ~w_pending[0];

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_nxt       = r_last;
        w_read_req_nxt   = r_read_req;
        w_sdram_addr_nxt = r_sdram_addr;
        w_sdram_bank_nxt = r_sdram_bank;
        w_tag_nxt        = r_tag;
        w_fill           = '0;
        case (r_state)
            ST_IDLE: begin
                if (!downloading && (|w_pending)) begin
                    w_owner_nxt      = w_grant;
                    w_tag_nxt        = w_slot_tag[w_grant];
                    w_sdram_addr_nxt = pair_addr(w_slot_tag[w_grant]);
                    w_sdram_bank_nxt = w_grant ? SLOT1_BANK : SLOT0_BANK;
                    w_read_req_nxt   = 1'b1;
                    w_state_nxt      = ST_WAIT_ACK;
                    if (&w_pending) begin
                        w_last_nxt = w_grant;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (sdram_ack) begin
                    w_read_req_nxt = 1'b0;
                    w_state_nxt    = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (data_rdy) begin
                    // A download in progress lets the handshake finish but discards the data
                    w_fill[r_owner] = !downloading;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_read_req_nxt = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last       <= 1'b1;
            r_read_req   <= 1'b0;
            r_sdram_addr <= '0;
            r_sdram_bank <= '0;
            r_tag        <= '0;
            r_refresh_en <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last       <= w_last_nxt;
            r_read_req   <= w_read_req_nxt;
            r_sdram_addr <= w_sdram_addr_nxt;
            r_sdram_bank <= w_sdram_bank_nxt;
            r_tag        <= w_tag_nxt;
            r_refresh_en <= (r_state == ST_IDLE) && !(|w_pending);
        end
    end

endmodule

`default_nettype wire
